// File: rtl/mem_bus_pkg.sv
// Shared encodings for the memory bus controller: requester ids, FSM states
// and the write-size code that selects a full two-beat line.
package mem_bus_pkg;

    localparam logic [1:0] SRC_IC  = 2'd0;
    localparam logic [1:0] SRC_DC  = 2'd1;
    localparam logic [1:0] SRC_DMA = 2'd2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BEAT0 = 2'd1;
    localparam logic [1:0] ST_BEAT1 = 2'd2;
    localparam logic [1:0] ST_FIN   = 2'd3;

    localparam logic [2:0] WSIZE_LINE = 3'd0;

    function automatic logic [1:0] onehot_to_src(input logic [2:0] oh);
        if (oh[2]) return SRC_DMA;
        if (oh[1]) return SRC_DC;
        return SRC_IC;
    endfunction

    function automatic logic [2:0] src_to_onehot(input logic [1:0] src);
        case (src)
            SRC_DC:  return 3'b010;
            SRC_DMA: return 3'b100;
            default: return 3'b001;
        endcase
    endfunction

endpackage

// File: rtl/mem_bus_if.sv
// Requester and memory-port signal bundle of the memory bus controller.
// Handshake: a requester holds REQ until its DONE pulse; GNT is high from acceptance through FIN; RVALID and DONE are single-cycle pulses to the owner.
interface mem_bus_if #(
    parameter int ADDR_W = 15
);
    logic [2:0]          REQ;
    logic [3*ADDR_W-1:0] REQ_ADDR;
    logic [2:0]          REQ_WR;
    logic [8:0]          REQ_SIZE;
    logic [383:0]        REQ_WDATA;
    logic [2:0]          GNT;
    logic                BEAT;
    logic [127:0]        RDATA;
    logic [2:0]          RVALID;
    logic [2:0]          DONE;
    logic [ADDR_W-1:0]   MEM_ADDR;
    logic                MEM_WR;
    logic                MEM_EN;
    logic [2:0]          MEM_WRITE_SIZE;
    logic [2:0]          MEM_SRC;
    logic [127:0]        MEM_WDATA;
    logic [127:0]        MEM_RDATA;

    modport slave (
        input  REQ, REQ_ADDR, REQ_WR, REQ_SIZE, REQ_WDATA, MEM_RDATA,
        output GNT, BEAT, RDATA, RVALID, DONE,
        output MEM_ADDR, MEM_WR, MEM_EN, MEM_WRITE_SIZE, MEM_SRC, MEM_WDATA
    );

    modport master (
        output REQ, REQ_ADDR, REQ_WR, REQ_SIZE, REQ_WDATA, MEM_RDATA,
        input  GNT, BEAT, RDATA, RVALID, DONE,
        input  MEM_ADDR, MEM_WR, MEM_EN, MEM_WRITE_SIZE, MEM_SRC, MEM_WDATA
    );

endinterface

// File: rtl/rr_arbiter3.sv
// Combinational three-way round-robin arbiter; priority starts at the source
// after the last-served one, which the parent keeps in a register.
module rr_arbiter3
    import mem_bus_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] last,
    output logic [2:0] gnt
);

    always_comb begin
        gnt = 3'b000;
        case (last)
            SRC_IC: begin
                if      (req[1]) gnt = 3'b010;
                else if (req[2]) gnt = 3'b100;
                else if (req[0]) gnt = 3'b001;
            end
            SRC_DC: begin
                if      (req[2]) gnt = 3'b100;
                else if (req[0]) gnt = 3'b001;
                else if (req[1]) gnt = 3'b010;
            end
            default: begin
                if      (req[0]) gnt = 3'b001;
                else if (req[1]) gnt = 3'b010;
                else if (req[2]) gnt = 3'b100;
            end
        endcase
    end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Memory bus controller: round-robin arbitration of IC/DC/DMA and one- or
// two-beat sequencing of the winning transaction onto the memory port.
module mem_bus_ctrl
    import mem_bus_pkg::*;
#(
    parameter int MEM_LAT = 4,
    parameter int ADDR_W  = 15
) (
    input  logic       CLK,
    input  logic       CLR,
    mem_bus_if.slave   bus,
    output logic [1:0] dbg_state
);

    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    logic [1:0]        state;
    logic [1:0]        owner;
    logic [1:0]        last_src;
    logic [ADDR_W-1:0] lat_addr;
    logic              lat_wr;
    logic [2:0]        lat_size;
    logic [3:0]        cnt;
    logic [2:0]        gnt_r;
    logic [127:0]      rdata_r;
    logic [2:0]        rvalid_r;

    logic [2:0]        arb_gnt;
    logic [1:0]        win;
    logic [ADDR_W-1:0] win_addr;
    logic              win_wr;
    logic [2:0]        win_size;
    logic              in_beat;
    logic              single_beat;

    rr_arbiter3 u_arb (
        .req  (bus.REQ),
        .last (last_src),
        .gnt  (arb_gnt)
    );

    always_comb begin
        win      = onehot_to_src(arb_gnt);
        win_addr = bus.REQ_ADDR[0 +: ADDR_W];
        win_wr   = bus.REQ_WR[0];
        win_size = bus.REQ_SIZE[2:0];
        case (win)
            SRC_DC: begin
                win_addr = bus.REQ_ADDR[ADDR_W +: ADDR_W];
                win_wr   = bus.REQ_WR[1];
                win_size = bus.REQ_SIZE[5:3];
            end
            SRC_DMA: begin
                win_addr = bus.REQ_ADDR[2*ADDR_W +: ADDR_W];
                win_wr   = bus.REQ_WR[2];
                win_size = bus.REQ_SIZE[8:6];
            end
            default: ;
        endcase
    end

    // A sized write touches one beat only; reads and full-line writes take two.
    assign single_beat = lat_wr && (lat_size != WSIZE_LINE);
    assign in_beat     = (state == ST_BEAT0) || (state == ST_BEAT1);

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state    <= ST_IDLE;
            owner    <= SRC_IC;
            last_src <= SRC_DMA;
            lat_addr <= '0;
            lat_wr   <= 1'b0;
            lat_size <= WSIZE_LINE;
            cnt      <= 4'd0;
            gnt_r    <= 3'b000;
            rdata_r  <= '0;
            rvalid_r <= 3'b000;
        end else begin
            rvalid_r <= 3'b000;
            case (state)
                ST_IDLE: begin
                    if (|bus.REQ) begin
                        state    <= ST_BEAT0;
                        owner    <= win;
                        gnt_r    <= arb_gnt;
                        lat_addr <= win_addr;
                        lat_wr   <= win_wr;
                        lat_size <= win_size;
                        cnt      <= LAT_M1;
                    end
                end
                ST_BEAT0, ST_BEAT1: begin
                    if (cnt == 4'd0) begin
                        cnt <= LAT_M1;
                        if (!lat_wr) begin
                            rdata_r  <= bus.MEM_RDATA;
                            rvalid_r <= src_to_onehot(owner);
                        end
                        state <= (state == ST_BEAT0 && !single_beat) ? ST_BEAT1 : ST_FIN;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    gnt_r    <= 3'b000;
                    last_src <= owner;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        bus.MEM_ADDR       = '0;
        bus.MEM_EN         = in_beat;
        bus.MEM_WR         = in_beat && lat_wr;
        bus.MEM_WRITE_SIZE = 3'd0;
        bus.MEM_SRC        = 3'd0;
        if (in_beat) begin
            bus.MEM_ADDR       = single_beat ? lat_addr
                                             : {lat_addr[ADDR_W-1:5], state == ST_BEAT1, 4'b0000};
            bus.MEM_WRITE_SIZE = lat_size;
            bus.MEM_SRC        = {1'b0, owner};
        end
    end

    always_comb begin
        case (owner)
            SRC_DC:  bus.MEM_WDATA = bus.REQ_WDATA[255:128];
            SRC_DMA: bus.MEM_WDATA = bus.REQ_WDATA[383:256];
            default: bus.MEM_WDATA = bus.REQ_WDATA[127:0];
        endcase
    end

    assign bus.GNT    = gnt_r;
    assign bus.BEAT   = (state == ST_BEAT1);
    assign bus.RDATA  = rdata_r;
    assign bus.RVALID = rvalid_r;
    assign bus.DONE   = (state == ST_FIN) ? src_to_onehot(owner) : 3'b000;
    assign dbg_state  = state;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Bench for mem_bus_ctrl: directed vector table, random transactions against a
// line-level memory model, arbitration, mid-transaction reset and MEM_LAT=1.
module tb_mem_bus_ctrl;
    import mem_bus_pkg::*;

    localparam int LAT = 4;
    localparam int AW  = 15;

    logic CLK = 1'b0;
    logic CLR;
    always #5 CLK = ~CLK;

    mem_bus_if #(.ADDR_W(AW)) bus  ();
    mem_bus_if #(.ADDR_W(AW)) bus1 ();
    logic [1:0] dbg_state;
    logic [1:0] dbg_state1;

    mem_bus_ctrl #(.MEM_LAT(LAT), .ADDR_W(AW)) u_dut (
        .CLK(CLK), .CLR(CLR), .bus(bus), .dbg_state(dbg_state)
    );
    mem_bus_ctrl #(.MEM_LAT(1), .ADDR_W(AW)) u_dut1 (
        .CLK(CLK), .CLR(CLR), .bus(bus1), .dbg_state(dbg_state1)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [127:0] exp_q[$];
    logic [127:0] wd_lo[3];
    logic [127:0] wd_hi[3];
    logic [127:0] ref_mem[2048];
    logic [127:0] dev_mem[2048];
    logic         dev_init = 1'b0;

    typedef struct {
        int           src;
        logic [AW-1:0] addr;
        logic         wr;
        logic [2:0]   size;
        logic [127:0] lo;
        logic [127:0] hi;
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
    } vec_t;
    vec_t vt[11];

    function automatic logic [127:0] pat(input int i);
        return {32'(i) * 32'h9E37_79B1, ~32'(i), 32'(i) ^ 32'hA5A5_5A5A, 32'(i) + 32'h1234_5678};
    endfunction

    // Byte-lane merge of a sized write into one 128-bit memory beat.
    function automatic logic [127:0] merge(input logic [127:0] old, input logic [127:0] wd,
                                           input logic [3:0] off, input logic [2:0] size);
        logic [127:0] r;
        r = old;
        if (size == 3'd0) return wd;
        for (int b = 0; b < 4; b++)
            if (b < int'(size) && int'(off) + b < 16) r[(int'(off) + b) * 8 +: 8] = wd[b * 8 +: 8];
        return r;
    endfunction

    function automatic logic [AW-1:0] beat_addr(input logic [AW-1:0] a, input logic wr,
                                                input logic [2:0] sz, input int beat);
        if (wr && sz != 3'd0) return a;
        return AW'((int'(a) / 32) * 32 + beat * 16);
    endfunction

    // Memory device on the main controller's port.
    assign bus.MEM_RDATA = dev_mem[bus.MEM_ADDR[AW-1:4]];
    always @(posedge CLK) begin
        if (!dev_init) begin
            for (int i = 0; i < 2048; i++) dev_mem[i] <= pat(i);
            dev_init <= 1'b1;
        end else if (bus.MEM_EN && bus.MEM_WR) begin
            dev_mem[bus.MEM_ADDR[AW-1:4]] <= merge(dev_mem[bus.MEM_ADDR[AW-1:4]], bus.MEM_WDATA,
                                                   bus.MEM_ADDR[3:0], bus.MEM_WRITE_SIZE);
        end
    end

    always_comb begin
        bus.REQ_WDATA = '0;
        for (int i = 0; i < 3; i++) bus.REQ_WDATA[i * 128 +: 128] = bus.BEAT ? wd_hi[i] : wd_lo[i];
    end

    assign bus1.MEM_RDATA = {8{1'b0, bus1.MEM_ADDR}};
    assign bus1.REQ_WDATA = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: bound expired or data missing", name);
    endtask

    function automatic logic [39:0] mk_vec(input logic [2:0] gnt, input logic beat, input logic en,
                                           input logic wr, input logic [2:0] ws, input logic [2:0] src,
                                           input logic [2:0] done, input logic [2:0] rv,
                                           input logic [AW-1:0] addr);
        return {7'd0, gnt, beat, en, wr, ws, src, done, rv, addr};
    endfunction

    function automatic logic [39:0] obs_vec();
        return mk_vec(bus.GNT, bus.BEAT, bus.MEM_EN, bus.MEM_WR, bus.MEM_WRITE_SIZE, bus.MEM_SRC,
                      bus.DONE, bus.RVALID, bus.MEM_EN ? bus.MEM_ADDR : '0);
    endfunction

    task automatic cycle();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic apply_reset();
        CLR = 1'b0;
        repeat (3) @(negedge CLK);
        CLR = 1'b1;
    endtask

    task automatic wait_idle();
        int c;
        for (c = 0; c < 40; c++) begin
            cycle();
            if (dbg_state == ST_IDLE && bus.GNT == 3'b000) break;
        end
        if (c == 40) fail_now("wait_idle");
    endtask

    // Driver + per-cycle checker for one transaction started from IDLE.
    task automatic run_txn(input int src, input logic [AW-1:0] addr, input logic wr,
                           input logic [2:0] size, input logic [127:0] lo, input logic [127:0] hi,
                           input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic hold,
                           output logic [127:0] got_lo);
        int nb, total;
        logic [2:0] oh;
        logic [AW-1:0] ea;
        logic ein, eb, erv, edone;
        logic [127:0] e;
        nb    = (wr && size != 3'd0) ? 1 : 2;
        total = nb * LAT + 1;
        oh    = 3'(1 << src);
        wd_lo[src] = lo;
        wd_hi[src] = hi;
        bus.REQ_ADDR[src * AW +: AW] = addr;
        bus.REQ_WR[src] = wr;
        bus.REQ_SIZE[src * 3 +: 3] = size;
        bus.REQ[src] = 1'b1;
        if (!wr) begin
            exp_q.push_back(ref_mem[{addr[AW-1:5], 1'b0}]);
            exp_q.push_back(ref_mem[{addr[AW-1:5], 1'b1}]);
        end
        got_lo = '0;
        for (int k = 1; k <= total + 1; k++) begin
            cycle();
            ein   = (k <= nb * LAT);
            eb    = ein && (k > LAT);
            ea    = eb ? a1 : a0;
            erv   = !wr && k > 1 && k <= total && ((k - 1) % LAT == 0);
            edone = (k == total);
            check($sformatf("bus src%0d k=%0d", src, k), {88'd0, obs_vec()},
                  {88'd0, mk_vec((k <= total) ? oh : 3'b000, eb, ein, ein && wr,
                                 ein ? size : 3'd0, ein ? 3'(src) : 3'd0,
                                 edone ? oh : 3'b000, erv ? oh : 3'b000, ein ? ea : '0)});
            if (ein && wr) check($sformatf("wdata k=%0d", k), bus.MEM_WDATA, eb ? hi : lo);
            if (erv) begin
                if (exp_q.size() == 0) fail_now("rdata_queue");
                else begin
                    e = exp_q.pop_front();
                    check($sformatf("rdata k=%0d", k), bus.RDATA, e);
                    if (k == LAT + 1) got_lo = bus.RDATA;
                end
            end
            if ((!hold && k == 1) || k == total) bus.REQ[src] = 1'b0;
        end
        if (wr) begin
            if (size == WSIZE_LINE) begin
                ref_mem[{addr[AW-1:5], 1'b0}] = lo;
                ref_mem[{addr[AW-1:5], 1'b1}] = hi;
            end else begin
                ref_mem[addr[AW-1:4]] = merge(ref_mem[addr[AW-1:4]], lo, addr[3:0], size);
            end
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [127:0] got;
        logic [2:0]   rr_got[$];
        logic [2:0]   prev;
        logic [2:0]   rr_exp[4];
        logic [AW-1:0] a;
        logic w;
        logic [2:0] sz;
        int s;

        for (int i = 0; i < 2048; i++) ref_mem[i] = pat(i);
        for (int i = 0; i < 3; i++) begin
            wd_lo[i] = '0;
            wd_hi[i] = '0;
        end
        bus.REQ = '0;  bus.REQ_ADDR = '0;  bus.REQ_WR = '0;  bus.REQ_SIZE = '0;
        bus1.REQ = '0; bus1.REQ_ADDR = '0; bus1.REQ_WR = '0; bus1.REQ_SIZE = '0;

        vt[0]  = '{0, 15'h1240, 1'b0, 3'd0, 128'h0, 128'h0, 15'h1240, 15'h1250};
        vt[1]  = '{1, 15'h0123, 1'b1, 3'd2, 128'hBEEF, 128'h0, 15'h0123, 15'h0123};
        vt[2]  = '{1, 15'h0120, 1'b0, 3'd0, 128'h0, 128'h0, 15'h0120, 15'h0130};
        vt[3]  = '{2, 15'h2000, 1'b1, 3'd0, 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF,
                   128'hFEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978, 15'h2000, 15'h2010};
        vt[4]  = '{0, 15'h2000, 1'b0, 3'd0, 128'h0, 128'h0, 15'h2000, 15'h2010};
        vt[5]  = '{2, 15'h2005, 1'b1, 3'd1, 128'hA5, 128'h0, 15'h2005, 15'h2005};
        vt[6]  = '{0, 15'h201C, 1'b1, 3'd3, 128'h11_2233, 128'h0, 15'h201C, 15'h201C};
        vt[7]  = '{1, 15'h2008, 1'b1, 3'd4, 128'hCAFE_F00D, 128'h0, 15'h2008, 15'h2008};
        vt[8]  = '{2, 15'h2017, 1'b0, 3'd0, 128'h0, 128'h0, 15'h2000, 15'h2010};
        vt[9]  = '{0, 15'h0AAF, 1'b1, 3'd0, 128'h1, 128'h2, 15'h0AA0, 15'h0AB0};
        vt[10] = '{1, 15'h0AB3, 1'b0, 3'd0, 128'h0, 128'h0, 15'h0AA0, 15'h0AB0};

        // Reset state.
        CLR = 1'b0;
        repeat (3) @(negedge CLK);
        check("reset bus", {88'd0, obs_vec()}, 128'd0);
        check("reset rdata", bus.RDATA, 128'd0);
        check("reset state", {126'd0, dbg_state}, {126'd0, ST_IDLE});
        check("reset l1 gnt/done", {122'd0, bus1.GNT, bus1.DONE}, 128'd0);
        CLR = 1'b1;

        // Directed vector table.
        for (int i = 0; i < 11; i++) begin
            run_txn(vt[i].src, vt[i].addr, vt[i].wr, vt[i].size, vt[i].lo, vt[i].hi,
                    vt[i].a0, vt[i].a1, 1'b1, got);
            if (i == 2) check("beef bytes 3-4", {112'd0, got[39:24]}, 128'hBEEF);
        end

        // Random transactions against the reference memory.
        for (int i = 0; i < 40; i++) begin
            s  = int'($urandom_range(0, 2));
            w  = 1'($urandom_range(0, 1));
            sz = w ? 3'($urandom_range(0, 4)) : 3'd0;
            a  = AW'(15'h3000 + $urandom_range(0, 255));
            if (w && sz != 3'd0) a[3:0] = 4'($urandom_range(0, 16 - int'(sz)));
            run_txn(s, a, w, sz, {$urandom, $urandom, $urandom, $urandom},
                    {$urandom, $urandom, $urandom, $urandom},
                    beat_addr(a, w, sz, 0), beat_addr(a, w, sz, 1), 1'($urandom_range(0, 1)), got);
        end

        // Continuous requests from all three sources after reset.
        apply_reset();
        bus.REQ_WR = 3'b000;
        bus.REQ_SIZE = '0;
        bus.REQ = 3'b111;
        prev = 3'b000;
        for (int c = 0; c < 80 && rr_got.size() < 4; c++) begin
            cycle();
            if (bus.GNT != 3'b000 && prev == 3'b000) rr_got.push_back(bus.GNT);
            prev = bus.GNT;
        end
        bus.REQ = 3'b000;
        rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001};
        if (rr_got.size() < 4) fail_now("rr grants");
        else for (int i = 0; i < 4; i++) check($sformatf("rr grant %0d", i), {125'd0, rr_got[i]}, {125'd0, rr_exp[i]});
        wait_idle();

        // Reset in the middle of a DMA read, after IC was last served.
        run_txn(0, 15'h0040, 1'b0, 3'd0, '0, '0, 15'h0040, 15'h0050, 1'b1, got);
        bus.REQ_ADDR[2 * AW +: AW] = 15'h0100;
        bus.REQ_WR[2] = 1'b0;
        bus.REQ[2] = 1'b1;
        repeat (3) cycle();
        check("pre-clr gnt", {125'd0, bus.GNT}, 128'b100);
        CLR = 1'b0;
        #1;
        check("clr bus", {88'd0, obs_vec()}, 128'd0);
        check("clr rdata", bus.RDATA, 128'd0);
        bus.REQ = 3'b000;
        for (int c = 0; c < 3; c++) begin
            cycle();
            check("clr no done", {125'd0, bus.DONE}, 128'd0);
        end
        CLR = 1'b1;
        bus.REQ = 3'b111;
        cycle();
        check("post-clr winner", {125'd0, bus.GNT}, 128'b001);
        bus.REQ = 3'b000;
        wait_idle();

        // MEM_LAT=1 read on the second controller.
        bus1.REQ_ADDR[AW-1:0] = 15'h1240;
        bus1.REQ[0] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            cycle();
            check($sformatf("l1 rvalid k=%0d", k), {125'd0, bus1.RVALID},
                  {125'd0, (k == 2 || k == 3) ? 3'b001 : 3'b000});
            check($sformatf("l1 done k=%0d", k), {125'd0, bus1.DONE}, {125'd0, (k == 3) ? 3'b001 : 3'b000});
            if (k <= 2) check($sformatf("l1 addr k=%0d", k), {113'd0, bus1.MEM_ADDR},
                              {113'd0, (k == 1) ? 15'h1240 : 15'h1250});
            if (k == 2) check("l1 rdata lo", bus1.RDATA, {8{16'h1240}});
            if (k == 3) check("l1 rdata hi", bus1.RDATA, {8{16'h1250}});
            if (k == 3) bus1.REQ[0] = 1'b0;
        end

        check("scoreboard drained", 128'(exp_q.size()), 128'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
